// File: rtl/mul_wb_scheduler.sv
// mul_wb_scheduler
//   Issue/writeback scheduler for the fixed-latency pipelined multiplier.
//   A credit counter gates new requests. Instruction IDs travel through a
//   latency-matched valid/id shift pipeline. Completed results are captured
//   into a small FIFO that drives the done/accepted writeback handshake.
//
// Ports
//   clk, rst      clock, synchronous active-high reset
//   new_request   issue wants to start a multiply this cycle
//   issue_id      ID of the requesting instruction
//   ready         a request can be accepted this cycle
//   mul_start     launch the datapath this cycle (new_request & ready)
//   mul_result    datapath output, valid MUL_LATENCY cycles after mul_start
//   done          FIFO head holds a valid result
//   rd, id        result and ID at the FIFO head
//   accepted      writeback takes the FIFO head this cycle
module mul_wb_scheduler #(
  parameter int MUL_LATENCY = 2,
  parameter int DEPTH       = 4,
  parameter int ID_W        = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            new_request,
  input  logic [ID_W-1:0] issue_id,
  output logic            ready,
  output logic            mul_start,
  input  logic [31:0]     mul_result,
  output logic            done,
  output logic [31:0]     rd,
  output logic [ID_W-1:0] id,
  input  logic            accepted
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  // Tracking pipeline: stage i holds the request launched i+1 cycles ago.
  logic            vld_p [MUL_LATENCY];
  logic [ID_W-1:0] id_p  [MUL_LATENCY];

  logic [31:0]     rd_mem [DEPTH];
  logic [ID_W-1:0] id_mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;

  // Total outstanding work: in-flight stages plus buffered results.
  logic [PW-1:0]   total_q;

  logic            capture;
  logic            pop;

  // ready comes only from the registered total, so a same-cycle pop never
  // opens a slot early; this is what keeps the FIFO from overflowing.
  assign ready     = (total_q < PW'(DEPTH));
  assign mul_start = new_request & ready;

  assign capture = vld_p[MUL_LATENCY-1];
  assign done    = (wr_ptr != rd_ptr);
  assign pop     = accepted & done;

  assign rd = rd_mem[rd_ptr[AW-1:0]];
  assign id = id_mem[rd_ptr[AW-1:0]];

  // ---- issue -> tracking pipeline (valid is control, id is data) ----
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MUL_LATENCY; i++) vld_p[i] <= 1'b0;
    end else begin
      vld_p[0] <= mul_start;
      for (int i = 1; i < MUL_LATENCY; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  always_ff @(posedge clk) begin
    id_p[0] <= issue_id;
    for (int i = 1; i < MUL_LATENCY; i++) id_p[i] <= id_p[i-1];
  end

  // ---- last tracking stage -> result FIFO ----
  always_ff @(posedge clk) begin
    if (capture) begin
      rd_mem[wr_ptr[AW-1:0]] <= mul_result;
      id_mem[wr_ptr[AW-1:0]] <= id_p[MUL_LATENCY-1];
    end
  end

  // Pointers carry one extra bit so that full and empty are distinguishable.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (capture) wr_ptr <= wr_ptr + PW'(1);
      if (pop)     rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Capture only moves work from the pipeline into the FIFO, so the total
  // changes solely on launch and on pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      total_q <= '0;
    end else if (mul_start && !pop) begin
      total_q <= total_q + PW'(1);
    end else if (!mul_start && pop) begin
      total_q <= total_q - PW'(1);
    end
  end

endmodule

// File: tb/tb_mul_wb_scheduler.sv
module tb_mul_wb_scheduler;

  localparam int L     = 2;
  localparam int DEPTH = 4;
  localparam int ID_W  = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic            new_request;
  logic [ID_W-1:0] issue_id;
  logic            ready;
  logic            mul_start;
  logic [31:0]     mul_result;
  logic            done;
  logic [31:0]     rd;
  logic [ID_W-1:0] id;
  logic            accepted;

  always #5 clk = ~clk;

  mul_wb_scheduler #(.MUL_LATENCY(L), .DEPTH(DEPTH), .ID_W(ID_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .new_request(new_request),
    .issue_id   (issue_id),
    .ready      (ready),
    .mul_start  (mul_start),
    .mul_result (mul_result),
    .done       (done),
    .rd         (rd),
    .id         (id),
    .accepted   (accepted)
  );

  // Datapath stand-in: returns the operand value tagged at launch L cycles later.
  logic [31:0] op_val;
  logic [31:0] dp_sr [L];
  always @(posedge clk) begin
    dp_sr[0] <= mul_start ? op_val : 32'hDEAD_BEEF;
    for (int i = 1; i < L; i++) dp_sr[i] <= dp_sr[i-1];
  end
  assign mul_result = dp_sr[L-1];

  // Reference model
  typedef struct {
    logic [ID_W-1:0] id;
    logic [31:0]     val;
    int              avail;
  } ent_t;
  ent_t mq[$];
  int   m_total = 0;
  int   cyc = 0;
  bit   exp_ready, exp_start, exp_done;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got=%h expected=%h", tag, cyc, got, exp);
    end
  endtask

  // Drive this cycle's inputs, then compare outputs against the model.
  task automatic set_in(input bit req, input int iid, input logic [31:0] val, input bit acc);
    new_request = req;
    issue_id    = iid[ID_W-1:0];
    op_val      = val;
    accepted    = acc;
    #1;
    exp_ready = (m_total < DEPTH);
    exp_start = req && exp_ready;
    exp_done  = (mq.size() > 0) && (mq[0].avail <= cyc);
    check("ready", {31'b0, ready}, {31'b0, exp_ready});
    check("mul_start", {31'b0, mul_start}, {31'b0, exp_start});
    check("done", {31'b0, done}, {31'b0, exp_done});
    if (exp_done) begin
      check("rd", rd, mq[0].val);
      check("id", {29'b0, id}, {29'b0, mq[0].id});
    end
  endtask

  // Advance the model and the clock; returns at posedge+1.
  task automatic tick();
    if (exp_start) mq.push_back('{id: issue_id, val: op_val, avail: cyc + L + 1});
    if (accepted && exp_done) void'(mq.pop_front());
    m_total = m_total + int'(exp_start) - int'(accepted && exp_done);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    new_request = 1'b0;
    accepted    = 1'b0;
    issue_id    = '0;
    op_val      = '0;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    m_total   = 0;
    exp_start = 1'b0;
    mq.delete();
    cyc++;
  endtask

  initial begin
    rst = 1'b1; new_request = 1'b0; accepted = 1'b0; issue_id = '0; op_val = '0;
    @(posedge clk);
    do_reset();

    // Reset state
    set_in(0, 0, 0, 0);
    check("rst_ready", {31'b0, ready}, 32'd1);
    check("rst_start", {31'b0, mul_start}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    tick();

    // Single request: id=1 at c0, result 0x15, done at c3, pop at c3
    do_reset();
    set_in(1, 1, 32'h15, 0);
    check("t1_start", {31'b0, mul_start}, 32'd1);
    tick();
    set_in(0, 0, 0, 0); tick();
    set_in(0, 0, 0, 0);
    check("t1_c2_done", {31'b0, done}, 32'd0);
    tick();
    set_in(0, 0, 0, 1);
    check("t1_done", {31'b0, done}, 32'd1);
    check("t1_rd", rd, 32'h15);
    check("t1_id", {29'b0, id}, 32'd1);
    tick();
    set_in(0, 0, 0, 0);
    check("t1_done_clr", {31'b0, done}, 32'd0);
    tick();

    // Credit exhaustion: four back-to-back issues with no writeback
    do_reset();
    for (int c = 0; c < 4; c++) begin
      set_in(1, c, 32'h20 + c, 0);
      check("t2_start", {31'b0, mul_start}, 32'd1);
      tick();
    end
    set_in(1, 4, 32'h24, 0);
    check("t2_ready_lo", {31'b0, ready}, 32'd0);
    check("t2_blocked", {31'b0, mul_start}, 32'd0);
    tick();
    set_in(1, 4, 32'h24, 1);
    check("t2_hold_ready", {31'b0, ready}, 32'd0);
    check("t2_pop_id", {29'b0, id}, 32'd0);
    tick();
    set_in(1, 4, 32'h24, 0);
    check("t2_ready_hi", {31'b0, ready}, 32'd1);
    check("t2_start_hi", {31'b0, mul_start}, 32'd1);
    tick();
    for (int c = 0; c < 10; c++) begin
      set_in(0, 0, 0, 1); tick();
    end

    // Streaming with accepted held high, pointer wrap
    do_reset();
    for (int c = 0; c < 16; c++) begin
      set_in(c < 12, c, 32'(c + 1), 1);
      if (c < 12) check("t3_ready", {31'b0, ready}, 32'd1);
      if (c >= 3 && c < 15) begin
        check("t3_done", {31'b0, done}, 32'd1);
        check("t3_rd", rd, 32'(c - 2));
      end
      tick();
    end
    set_in(0, 0, 0, 0);
    check("t3_empty", {31'b0, done}, 32'd0);
    tick();

    // Simultaneous capture and pop with three buffered entries
    do_reset();
    for (int c = 1; c <= 4; c++) begin
      set_in(1, c, 32'h30 + c, 0); tick();
    end
    set_in(0, 0, 0, 0); tick();
    for (int k = 1; k <= 4; k++) begin
      set_in(0, 0, 0, 1);
      check("t4_head_id", {29'b0, id}, 32'(k));
      check("t4_head_rd", rd, 32'h30 + k);
      tick();
    end
    set_in(0, 0, 0, 0);
    check("t4_drained", {31'b0, done}, 32'd0);
    tick();

    // Reset with two buffered and two in flight
    do_reset();
    for (int c = 0; c < 4; c++) begin
      set_in(1, c, 32'h40 + c, 0); tick();
    end
    do_reset();
    set_in(0, 0, 0, 0);
    check("t5_done", {31'b0, done}, 32'd0);
    check("t5_ready", {31'b0, ready}, 32'd1);
    tick();
    for (int c = 0; c < 6; c++) begin
      set_in(0, 0, 0, 1);
      check("t5_no_stale", {31'b0, done}, 32'd0);
      tick();
    end

    // Random issue/accept traffic against the reference queue
    do_reset();
    for (int c = 0; c < 1000; c++) begin
      set_in($urandom_range(0, 99) < 70, int'($urandom_range(0, 7)), $urandom, $urandom_range(0, 99) < 60);
      tick();
    end
    for (int c = 0; c < 12; c++) begin
      set_in(0, 0, 0, 1); tick();
    end
    set_in(0, 0, 0, 0);
    check("rand_drained", {31'b0, done}, 32'd0);
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
